reg_bank_sb: RTL and testbench
==============================

Name: reg_bank_sb

Overview:
- Parametrised successor to the processor register bank: configurable data width, register count and number of read ports.
- Adds write-to-read bypass, an optional hard-wired zero register, and a per-register busy scoreboard (reserve at issue, release at writeback) for pipeline hazard detection.
- Sits between decode (read, reserve) and writeback (write, release) in the ARM8 datapath.

Parameters:
- DW, 32, data width in bits.
- NREG, 32, number of registers; power of two, minimum 2.
- AW, $clog2(NREG), register address width; derived, not overridden.
- NRD, 2, number of read ports, 1..4.
- ZERO_R0, 0, when 1, register 0 reads as 0, ignores writes and is never busy.
- RST_V0, 32'h1, reset value of register 0 (unused when ZERO_R0=1).
- RST_V1, 32'h3, reset value of register 1.

Ports:
- clk  in  1  clock, all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- raddr  in  NRD*AW  read addresses; port i uses bits [i*AW +: AW].
- rdata  out  NRD*DW  read data; port i uses bits [i*DW +: DW].
- rbusy  out  NRD  busy bit of each addressed register.
- we  in  1  write enable (writeback).
- waddr  in  AW  write address.
- wdata  in  DW  write data.
- rsv  in  1  reserve request: mark rsv_addr busy.
- rsv_addr  in  AW  register to reserve.
- busy_cnt  out  AW+1  number of registers currently busy.

Behaviour:
- Storage: NREG x DW flops, plus an NREG-bit busy vector.
- Reset (rst=1 at a rising edge):
  - reg0 <= RST_V0, reg1 <= RST_V1, all other registers <= 0.
  - busy <= 0 and busy_cnt <= 0.
  - we and rsv in the same cycle are ignored.
  - Applies identically when a reserve or write is in flight.
- Write: if we=1 and not rst, reg[waddr] <= wdata and busy[waddr] <= 0 (release) at the edge.
- Reserve: if rsv=1 and not rst, busy[rsv_addr] <= 1 at the edge.
- Reserve and write to the same address in one cycle: data is written, busy ends at 1 (reserve wins; a new producer was issued).
- Reserve and write to different addresses: both take effect.
- Reserving an already-busy register is legal; it stays 1 and busy_cnt does not change.
- Writing a non-busy register is legal; busy stays 0.
- Read (combinational, zero latency):
  - rdata_i = (we && waddr==raddr_i && !(ZERO_R0 && raddr_i==0)) ? wdata : reg[raddr_i]. This is write-first bypass.
  - rbusy_i = busy[raddr_i] && !(we && waddr==raddr_i). A same-cycle release is visible.
  - Reads are not gated by rst; during reset, rdata shows the pre-reset contents combined with the bypass.
- ZERO_R0=1:
  - rdata_i = 0 and rbusy_i = 0 whenever raddr_i==0.
  - Writes and reserves to address 0 are dropped.
- busy_cnt:
  - Registered; always equals popcount(busy).
  - Updated by +1, -1 or 0 per cycle from the reserve/release deltas, with no full popcount.
  - Range 0..NREG; cannot wrap.
- Outputs after reset, with raddr=0: rdata_0 = RST_V0 (0 if ZERO_R0), rbusy = 0, busy_cnt = 0.

Decomposition:
- Shared package regbank_pkg:
  - Default DW/NREG constants.
  - Reset-value constants RST_V0/RST_V1.
  - The clog2 helper.
- One natural sub-module, reg_scoreboard: the busy vector, busy_cnt, and the release-visible rbusy logic, parametrised by NREG/NRD.
- Data storage and bypass mux stay in the top module.

Test Plan:
- Reset check (defaults): rst=1 for one edge, raddr0=0, raddr1=1 -> rdata0=32'h1, rdata1=32'h3, rbusy=2'b00, busy_cnt=0; all of regs 2..31 read 0.
- Write/bypass: we=1, waddr=5, wdata=32'hDEADBEEF, raddr0=5 in the same cycle -> rdata0=32'hDEADBEEF before the edge; after the edge with we=0, still 32'hDEADBEEF.
- Scoreboard basics:
  - rsv=1, rsv_addr=7 -> next cycle rbusy for raddr=7 is 1, busy_cnt=1.
  - Then we=1, waddr=7 -> rbusy=0 combinationally in that cycle; busy_cnt=0 after the edge.
- Simultaneous events:
  - rsv=1, rsv_addr=9 with we=1, waddr=9, wdata=32'h55 -> after the edge reg9=32'h55, busy[9]=1, busy_cnt=1.
  - rsv to 3 plus we to 9 -> busy_cnt stays 1 (3 set, 9 cleared).
- ZERO_R0=1 build: we=1, waddr=0, wdata=32'hFF, plus rsv to 0 -> rdata for raddr=0 is 0, rbusy=0, busy_cnt unchanged; reset value of reg0 is irrelevant.
- Reset mid-operation:
  - Reserve 4 registers (busy_cnt=4), write reg2=32'hA.
  - Assert rst together with we=1, waddr=2 -> after the edge, busy_cnt=0, reg2=0, reg1=32'h3.
  - Also run NRD=4 with all ports reading distinct addresses.

Source files
------------

// File: rtl/regbank_pkg.sv
// Shared constants and helpers for the scoreboarded register bank.
package regbank_pkg;

   localparam int DW_DEF   = 32;
   localparam int NREG_DEF = 32;
   localparam int NRD_DEF  = 2;

   localparam logic [31:0] RST_V0_DEF = 32'h1;
   localparam logic [31:0] RST_V1_DEF = 32'h3;

   // Ceiling log2. It is constant-evaluable, so it can size ports and localparams.
   function automatic int clog2(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return r;
   endfunction

endpackage

// File: rtl/reg_bank_sb_if.sv
// Decode/writeback port bundle of the register bank: reads, writeback, reserve and busy count.
interface reg_bank_sb_if
   import regbank_pkg::*;
#(
   parameter int DW   = DW_DEF,
   parameter int NREG = NREG_DEF,
   parameter int NRD  = NRD_DEF
);
   localparam int AW = clog2(NREG);

   logic [NRD*AW-1:0] raddr;
   logic [NRD*DW-1:0] rdata;
   logic [NRD-1:0]    rbusy;
   logic              we;
   logic [AW-1:0]     waddr;
   logic [DW-1:0]     wdata;
   logic              rsv;
   logic [AW-1:0]     rsv_addr;
   logic [AW:0]       busy_cnt;

   modport master (
      output raddr, we, waddr, wdata, rsv, rsv_addr,
      input  rdata, rbusy, busy_cnt
   );

   modport slave (
      input  raddr, we, waddr, wdata, rsv, rsv_addr,
      output rdata, rbusy, busy_cnt
   );

endinterface

// File: rtl/reg_bank_sb_scoreboard.sv
// Per-register busy scoreboard. A register is reserved at issue and released at writeback.
// A release in the current cycle is already visible on rbusy.
module reg_scoreboard
   import regbank_pkg::*;
#(
   parameter int NREG = NREG_DEF,
   parameter int NRD  = NRD_DEF,
   localparam int AW  = clog2(NREG)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              rsv,
   input  logic [AW-1:0]     rsv_addr,
   input  logic              we,
   input  logic [AW-1:0]     waddr,
   input  logic [NRD*AW-1:0] raddr,
   output logic [NRD-1:0]    rbusy,
   output logic [AW:0]       busy_cnt
);

   logic [NREG-1:0] busy;
   logic [NREG-1:0] busy_next;
   logic            inc;
   logic            dec;

   // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch can be inferred.
   always_comb begin
      busy_next = busy;
      if (we)  busy_next[waddr]    = 1'b0;
      if (rsv) busy_next[rsv_addr] = 1'b1;
   end

   // When reserve and release hit the same register, the reserve wins. That case can only increment.
   assign inc = rsv && !busy[rsv_addr];
   assign dec = we && busy[waddr] && !(rsv && rsv_addr == waddr);

   // NOTE: sequential state uses non-blocking '<=', so every flop samples its pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         busy     <= '0;
         busy_cnt <= '0;
      end else begin
         busy <= busy_next;
         case ({inc, dec})
            2'b10:   busy_cnt <= busy_cnt + (AW+1)'(1);
            2'b01:   busy_cnt <= busy_cnt - (AW+1)'(1);
            default: busy_cnt <= busy_cnt;
         endcase
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rbusy
      logic [AW-1:0] ra;
      assign ra       = raddr[i*AW +: AW];
      assign rbusy[i] = busy[ra] && !(we && waddr == ra);
   end

endmodule

// File: rtl/reg_bank_sb.sv
// Parametrised register bank with write-first bypass, an optional zero register and a busy scoreboard.
module reg_bank_sb
   import regbank_pkg::*;
#(
   parameter int          DW      = DW_DEF,
   parameter int          NREG    = NREG_DEF,
   parameter int          NRD     = NRD_DEF,
   parameter bit          ZERO_R0 = 1'b0,
   parameter logic [31:0] RST_V0  = RST_V0_DEF,
   parameter logic [31:0] RST_V1  = RST_V1_DEF,
   localparam int         AW      = clog2(NREG)
) (
   input  logic          clk,
   input  logic          rst,
   reg_bank_sb_if.slave  bus
);

   logic [DW-1:0] regs [NREG];
   logic          we_eff;
   logic          rsv_eff;

   // With a hard-wired zero register, traffic to address 0 never reaches storage or the scoreboard.
   assign we_eff  = bus.we  && !(ZERO_R0 && bus.waddr    == '0);
   assign rsv_eff = bus.rsv && !(ZERO_R0 && bus.rsv_addr == '0);

   // NOTE: the bank is built from flops rather than RAM, so each register gets a defined reset value.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int r = 0; r < NREG; r++) regs[r] <= '0;
         regs[0] <= DW'(RST_V0);
         regs[1] <= DW'(RST_V1);
      end else if (we_eff) begin
         regs[bus.waddr] <= bus.wdata;
      end
   end

   for (genvar i = 0; i < NRD; i++) begin : g_rd
      logic [AW-1:0] ra;
      assign ra = bus.raddr[i*AW +: AW];
      assign bus.rdata[i*DW +: DW] =
         (ZERO_R0 && ra == '0)         ? '0        :
         (bus.we && bus.waddr == ra)   ? bus.wdata :
                                         regs[ra];
   end

   reg_scoreboard #(
      .NREG (NREG),
      .NRD  (NRD)
   ) u_sb (
      .clk      (clk),
      .rst      (rst),
      .rsv      (rsv_eff),
      .rsv_addr (bus.rsv_addr),
      .we       (we_eff),
      .waddr    (bus.waddr),
      .raddr    (bus.raddr),
      .rbusy    (bus.rbusy),
      .busy_cnt (bus.busy_cnt)
   );

endmodule

// File: tb/tb_reg_bank_sb.sv
// Directed bench for reg_bank_sb covering the default, zero-register and four-read-port builds.
module tb_reg_bank_sb;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_pass   = 0;

   always #5 clk = ~clk;

   reg_bank_sb_if #(.DW(32), .NREG(32), .NRD(2)) ifd ();
   reg_bank_sb_if #(.DW(32), .NREG(32), .NRD(2)) ifz ();
   reg_bank_sb_if #(.DW(32), .NREG(32), .NRD(4)) if4 ();

   reg_bank_sb #(.DW(32), .NREG(32), .NRD(2), .ZERO_R0(1'b0)) u_def  (.clk(clk), .rst(rst), .bus(ifd));
   reg_bank_sb #(.DW(32), .NREG(32), .NRD(2), .ZERO_R0(1'b1)) u_zero (.clk(clk), .rst(rst), .bus(ifz));
   reg_bank_sb #(.DW(32), .NREG(32), .NRD(4), .ZERO_R0(1'b0)) u_four (.clk(clk), .rst(rst), .bus(if4));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      else n_pass++;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      ifd.raddr = {5'd1, 5'd0}; ifd.we = 0; ifd.waddr = 0; ifd.wdata = 0; ifd.rsv = 0; ifd.rsv_addr = 0;
      ifz.raddr = {5'd1, 5'd0}; ifz.we = 0; ifz.waddr = 0; ifz.wdata = 0; ifz.rsv = 0; ifz.rsv_addr = 0;
      if4.raddr = '0;           if4.we = 0; if4.waddr = 0; if4.wdata = 0; if4.rsv = 0; if4.rsv_addr = 0;

      // Reset defaults
      tick();
      rst = 1'b0;
      #1;
      check("rst_rdata0", ifd.rdata[31:0],  32'h1);
      check("rst_rdata1", ifd.rdata[63:32], 32'h3);
      check("rst_rbusy",  ifd.rbusy,        2'b00);
      check("rst_cnt",    ifd.busy_cnt,     0);
      for (int a = 2; a < 32; a++) begin
         ifd.raddr[4:0] = 5'(a);
         #1;
         check($sformatf("rst_reg%0d", a), ifd.rdata[31:0], 0);
      end

      // Write with same-cycle bypass
      ifd.we = 1; ifd.waddr = 5; ifd.wdata = 32'hDEADBEEF; ifd.raddr[4:0] = 5;
      #1;
      check("bypass_rd", ifd.rdata[31:0], 32'hDEADBEEF);
      tick();
      ifd.we = 0;
      #1;
      check("stored_rd", ifd.rdata[31:0], 32'hDEADBEEF);

      // Reserve, then a release that is visible in the same cycle
      ifd.rsv = 1; ifd.rsv_addr = 7;
      tick();
      ifd.rsv = 0; ifd.raddr[4:0] = 7;
      #1;
      check("rsv7_rbusy", ifd.rbusy[0], 1'b1);
      check("rsv7_cnt",   ifd.busy_cnt, 1);
      ifd.we = 1; ifd.waddr = 7; ifd.wdata = 32'h77;
      #1;
      check("rel7_rbusy_comb", ifd.rbusy[0], 1'b0);
      check("rel7_cnt_pre",    ifd.busy_cnt, 1);
      tick();
      ifd.we = 0;
      #1;
      check("rel7_cnt", ifd.busy_cnt, 0);

      // Reserve and write to the same register: data lands, busy stays set
      ifd.rsv = 1; ifd.rsv_addr = 9; ifd.we = 1; ifd.waddr = 9; ifd.wdata = 32'h55;
      tick();
      ifd.rsv = 0; ifd.we = 0; ifd.raddr[4:0] = 9;
      #1;
      check("same9_rdata", ifd.rdata[31:0], 32'h55);
      check("same9_rbusy", ifd.rbusy[0],    1'b1);
      check("same9_cnt",   ifd.busy_cnt,    1);

      // Reserve 3 while releasing 9
      ifd.rsv = 1; ifd.rsv_addr = 3; ifd.we = 1; ifd.waddr = 9; ifd.wdata = 32'h66;
      tick();
      ifd.rsv = 0; ifd.we = 0; ifd.raddr = {5'd9, 5'd3};
      #1;
      check("swap_cnt",   ifd.busy_cnt,      1);
      check("swap_rbusy", ifd.rbusy,         2'b01);
      check("swap_rd9",   ifd.rdata[63:32],  32'h66);

      // Zero-register build
      ifz.we = 1; ifz.waddr = 0; ifz.wdata = 32'hFF; ifz.rsv = 1; ifz.rsv_addr = 0; ifz.raddr = {5'd1, 5'd0};
      #1;
      check("z_rd0_comb",  ifz.rdata[31:0],  0);
      check("z_rbusy_comb", ifz.rbusy[0],    1'b0);
      check("z_rd1",       ifz.rdata[63:32], 32'h3);
      tick();
      ifz.we = 0; ifz.rsv = 0;
      #1;
      check("z_rd0",   ifz.rdata[31:0], 0);
      check("z_rbusy", ifz.rbusy,       2'b00);
      check("z_cnt",   ifz.busy_cnt,    0);
      ifz.rsv = 1; ifz.rsv_addr = 4;
      tick();
      ifz.rsv = 0; ifz.raddr[4:0] = 4;
      #1;
      check("z_rsv4_rbusy", ifz.rbusy[0], 1'b1);
      check("z_rsv4_cnt",   ifz.busy_cnt, 1);

      // Four read ports, distinct addresses, with a bypass on port 3
      if4.we = 1; if4.waddr = 4; if4.wdata = 32'h40;
      tick();
      if4.waddr = 5; if4.wdata = 32'h50;
      tick();
      if4.waddr = 6; if4.wdata = 32'h60; if4.raddr = {5'd6, 5'd5, 5'd4, 5'd1};
      #1;
      check("p4_rd0", if4.rdata[31:0],   32'h3);
      check("p4_rd1", if4.rdata[63:32],  32'h40);
      check("p4_rd2", if4.rdata[95:64],  32'h50);
      check("p4_rd3", if4.rdata[127:96], 32'h60);
      tick();
      if4.we = 0;

      // Build up four busy registers, then reset in the middle of a write
      for (int r = 10; r <= 12; r++) begin
         ifd.rsv = 1; ifd.rsv_addr = 5'(r);
         tick();
      end
      ifd.rsv = 0;
      #1;
      check("mid_cnt4", ifd.busy_cnt, 4);
      ifd.rsv = 1; ifd.rsv_addr = 10;
      tick();
      ifd.rsv = 0;
      #1;
      check("rersv_cnt", ifd.busy_cnt, 4);
      ifd.we = 1; ifd.waddr = 2; ifd.wdata = 32'hA; ifd.raddr = {5'd1, 5'd2};
      tick();
      #1;
      check("mid_reg2", ifd.rdata[31:0], 32'hA);
      ifd.waddr = 2; ifd.wdata = 32'hBB; ifd.rsv = 1; ifd.rsv_addr = 13;
      rst = 1;
      tick();
      rst = 0; ifd.we = 0; ifd.rsv = 0; ifd.raddr = {5'd10, 5'd2};
      #1;
      check("post_rst_cnt",   ifd.busy_cnt,     0);
      check("post_rst_reg2",  ifd.rdata[31:0],  0);
      check("post_rst_rbusy", ifd.rbusy,        2'b00);
      ifd.raddr = {5'd1, 5'd0};
      #1;
      check("post_rst_reg1", ifd.rdata[63:32], 32'h3);
      check("post_rst_reg0", ifd.rdata[31:0],  32'h1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
